// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with hold handshake and optional max hold rotation
module rr_arbiter8 #(
  parameter int MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] MH = MAX_HOLD[7:0];
  state_t state, state_n;
  logic [7:0] grant_n, hcnt, hcnt_n;
  logic [2:0] idx_n, ptr, ptr_n, start;
  logic [3:0] win;
  logic hold;
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] s);
    logic [15:0] d;
    logic [3:0] p;
    d = {r, r} >> s;
    p = '0;
    for (int i = 7; i >= 0; i--) if (d[i]) p = {1'b1, s + 3'(i)};
    return p;
  endfunction
  assign grant_valid = |grant;
  assign hold = state == GRANT && req[grant_idx] && (MH == 8'd0 || hcnt < MH);
  assign start = state == GRANT ? grant_idx + 3'd1 : ptr;
  assign win = pick(req, start);
  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n = grant_idx;
    ptr_n = ptr;
    hcnt_n = hcnt;
    if (hold) hcnt_n = hcnt + {7'd0, hcnt != 8'hff};
    else begin
      ptr_n = state == GRANT ? start : ptr;
      state_n = win[3] ? GRANT : IDLE;
      grant_n = win[3] ? 8'd1 << win[2:0] : 8'd0;
      idx_n = win[3] ? win[2:0] : grant_idx;
      hcnt_n = {7'd0, win[3]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      ptr <= '0;
      hcnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      ptr <= ptr_n;
      hcnt <= hcnt_n;
    end
  end
endmodule
